aes_lite_job_scheduler: RTL and testbench
=========================================

Name: aes_lite_job_scheduler

Overview:
Two-requester front end that shares a single 8-bit AES-lite encryption core. It accepts jobs (data and key) over valid/ready handshakes and arbitrates between requesters. It issues each job to the core with a start pulse, waits for the core's done/ready, and returns the result with a requester tag. A watchdog aborts jobs whose core never signals done.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before abort (>=2)
CNT_W, 7, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 job available
req0_ready  out  1  requester 0 job accepted this cycle
req0_data  in  8  requester 0 plaintext
req0_key  in  8  requester 0 key
req1_valid  in  1  requester 1 job available
req1_ready  out  1  requester 1 job accepted this cycle
req1_data  in  8  requester 1 plaintext
req1_key  in  8  requester 1 key
core_start  out  1  one-cycle start pulse to core
core_data  out  8  plaintext to core, held stable ISSUE..WAIT
core_key  out  8  key to core, held stable ISSUE..WAIT
core_done  in  1  core result valid (sampled in WAIT only)
core_result  in  8  core ciphertext
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  8  ciphertext (0x00 on abort)
out_tag  out  1  requester id of result
out_err  out  1  result was a watchdog abort
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous, active-high. All registers clear immediately on rst.
- Reset values: state=IDLE; core_start, out_valid, out_err, out_tag, busy all 0; core_data, core_key, out_data 0x00; last_grant=1, so req1 was last served and req0 wins the first tie; watchdog count 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the one not equal to last_grant (round-robin).
  - reqN_ready is combinational, high only for the granted requester and only in IDLE. A transfer occurs when valid&&ready.
  - On a transfer: latch data/key into core_data/core_key, latch the tag, set last_grant=tag, go to ISSUE.
- ISSUE: core_start=1 for exactly this one cycle. Clear the watchdog count, then go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - If core_done=1: latch core_result into out_data, out_err=0, go to OUT.
  - Else if count==TIMEOUT-1: out_data=0x00, out_err=1, go to OUT.
  - If core_done and timeout coincide, core_done wins.
- OUT:
  - out_valid=1; out_data, out_tag and out_err are held stable.
  - On out_ready=1: out_valid falls next cycle and the FSM returns to IDLE.
  - No new job is accepted in OUT; there is no skid.
- Latency: a request accepted at edge N gives core_start high in cycle N+1. A core_done sampled at edge M gives out_valid high from M+1.
- Throughput: at most one job in flight. Back-to-back jobs need a minimum of 4 cycles plus core latency.
- Outputs core_start, out_valid and busy are registered, not combinational.
- Requester inputs are ignored outside IDLE. A requester dropping valid before it is granted is legal and causes no transfer.
- rst mid-job: the job is discarded, no result is emitted, and the core is expected to be reset by the same reset.

Optional Feature:
AES_SCHED_PRIO_EN
- Defined: fixed priority, req0 always wins a tie; last_grant is still updated but ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset then single job: req0 data=0xAA key=0x55; core model returns data^key after 3 cycles -> core_start pulses once, then out_valid with out_data=0xFF, out_tag=0, out_err=0.
- Contention: req0 (0x12,0x34) and req1 (0x5A,0xA5) both held valid, out_ready=1 -> results in order tag0=0x26, tag1=0xFF, tag0 again on the next reuse. With AES_SCHED_PRIO_EN, req0 is served repeatedly while it stays valid.
- Backpressure: out_ready=0 for 10 cycles -> out_valid, out_data and out_tag are held constant, req ready lines stay 0, and core_start does not pulse again.
- Watchdog: core_done is never asserted -> out_valid exactly TIMEOUT cycles after WAIT entry, with out_err=1 and out_data=0x00. A done arriving in the timeout cycle gives out_err=0.
- Reset mid-WAIT: assert rst asynchronously -> all outputs reach their reset values without a clock edge, and no out_valid appears after release.
- Boundary data: (0xFF,0xFF) and (0x00,0x00) -> out_data 0x00 for both with out_err=0; busy stays high from ISSUE through OUT.

Source files
------------

// File: rtl/aes_lite_job_scheduler.sv
// Two-requester job scheduler in front of a shared 8-bit AES-lite core, with watchdog abort.
// Optional build macro AES_SCHED_PRIO_EN: fixed req0 priority on ties instead of round-robin.
module aes_lite_job_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    input  logic [7:0] req0_key,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    input  logic [7:0] req1_key,
    output logic       core_start,
    output logic [7:0] core_data,
    output logic [7:0] core_key,
    input  logic       core_done,
    input  logic [7:0] core_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_tag,
    output logic       out_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [7:0]       core_data_q, core_data_d;
    logic [7:0]       core_key_q, core_key_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_start_q, core_start_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             grant;
    logic             grant_vld;

    // Tie-break: round-robin favours the requester not served last.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef AES_SCHED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        core_data_d  = core_data_q;
        core_key_d   = core_key_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        cnt_d        = cnt_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant_vld && !grant;
                req1_ready = grant_vld && grant;
                if (grant_vld) begin
                    core_data_d  = grant ? req1_data : req0_data;
                    core_key_d   = grant ? req1_key  : req0_key;
                    out_tag_d    = grant;
                    last_grant_d = grant;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done in the final watchdog cycle still counts as success.
                if (core_done) begin
                    out_data_d = core_result;
                    out_err_d  = 1'b0;
                    state_d    = OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    out_data_d = 8'h00;
                    out_err_d  = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        core_start_d = (state_d == ISSUE);
        out_valid_d  = (state_d == OUT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            core_data_q  <= 8'h00;
            core_key_q   <= 8'h00;
            out_data_q   <= 8'h00;
            out_tag_q    <= 1'b0;
            out_err_q    <= 1'b0;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            core_data_q  <= core_data_d;
            core_key_q   <= core_key_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign core_start = core_start_q;
    assign core_data  = core_data_q;
    assign core_key   = core_key_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_lite_job_scheduler.sv
// Directed self-checking bench for aes_lite_job_scheduler with a simple XOR core model.
// Stimulus changes and output sampling happen on the falling clock edge.
module tb_aes_lite_job_scheduler;

   localparam int TIMEOUT = 64;

   logic       clk;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_data, req0_key, req1_data, req1_key;
   logic       core_start;
   logic [7:0] core_data, core_key;
   logic       core_done;
   logic [7:0] core_result;
   logic       out_valid, out_ready;
   logic [7:0] out_data;
   logic       out_tag, out_err, busy;

   logic       model_en, model_done, man_done;
   logic [7:0] model_res, man_result;

   int checks = 0;
   int errors = 0;

   assign core_done   = model_done | man_done;
   assign core_result = model_done ? model_res : man_result;

   aes_lite_job_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
      .core_start(core_start), .core_data(core_data), .core_key(core_key),
      .core_done(core_done), .core_result(core_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Core model: returns data^key with done high for one cycle, three cycles after start.
   initial begin
      model_done = 1'b0;
      model_res  = 8'h00;
      forever begin
         @(negedge clk);
         if (model_en && core_start && !rst) begin
            model_res = core_data ^ core_key;
            repeat (3) @(negedge clk);
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      out_ready = 1'b0;
      man_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({core_start, out_valid, out_err, out_tag, busy, req0_ready, req1_ready} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                  {core_start, out_valid, out_err, out_tag, busy, req0_ready, req1_ready});
      end
      checks++;
      if ({core_data, core_key, out_data} !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 000000", {core_data, core_key, out_data});
      end
      rst = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_first_tie: got %b expected 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL ready_no_valid: got %b expected 00", {req0_ready, req1_ready});
      end
   endtask

   task automatic test_single_job();
      int cycles;
      int starts;
      model_en = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      req0_data = 8'hAA;
      req0_key = 8'h55;
      req0_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b expected 1", req0_ready);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      checks++;
      if ({core_start, busy, core_data, core_key} !== {1'b1, 1'b1, 8'hAA, 8'h55}) begin
         errors++;
         $display("[TB] FAIL single_issue: got %h expected 3aa55", {core_start, busy, core_data, core_key});
      end
      cycles = 0;
      starts = 0;
      while (!out_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (core_start) starts++;
      end
      checks++;
      if (cycles !== 4) begin
         errors++;
         $display("[TB] FAIL single_latency: got %0d cycles expected 4", cycles);
      end
      checks++;
      if ({out_valid, out_data, out_tag, out_err} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL single_result: got %h expected 7fc", {out_valid, out_data, out_tag, out_err});
      end
      checks++;
      if (starts !== 0) begin
         errors++;
         $display("[TB] FAIL single_start_pulses: got %0d extra expected 0", starts);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL single_release: got %b expected 00", {out_valid, busy});
      end
      out_ready = 1'b0;
   endtask

   task automatic test_contention();
      logic [7:0] exp_data [3];
      logic       exp_tag [3];
      int cycles;
      exp_data[0] = 8'h26; exp_tag[0] = 1'b0;
`ifdef AES_SCHED_PRIO_EN
      exp_data[1] = 8'h26; exp_tag[1] = 1'b0;
`else
      exp_data[1] = 8'hFF; exp_tag[1] = 1'b1;
`endif
      exp_data[2] = 8'h26; exp_tag[2] = 1'b0;
      do_reset();
      model_en = 1'b1;
      out_ready = 1'b1;
      req0_data = 8'h12; req0_key = 8'h34;
      req1_data = 8'h5A; req1_key = 8'hA5;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycles = 0;
         do begin
            @(negedge clk);
            cycles++;
         end while (!out_valid && cycles < 20);
         checks++;
         if ({out_valid, out_tag, out_data, out_err} !== {1'b1, exp_tag[k], exp_data[k], 1'b0}) begin
            errors++;
            $display("[TB] FAIL contention_%0d: got v=%b tag=%b data=%h err=%b expected v=1 tag=%b data=%h err=0",
                     k, out_valid, out_tag, out_data, out_err, exp_tag[k], exp_data[k]);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cycles;
      model_en = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      req1_data = 8'h3C;
      req1_key = 8'h0F;
      req1_valid = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_arrive: got out_valid=%b after %0d cycles expected 1", out_valid, cycles);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({out_valid, out_data, out_tag, out_err, req0_ready, req1_ready, core_start} !==
             {1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bp_hold_%0d: got v=%b d=%h t=%b e=%b r0=%b r1=%b s=%b expected v=1 d=33 t=1 e=0 r0=0 r1=0 s=0",
                     i, out_valid, out_data, out_tag, out_err, req0_ready, req1_ready, core_start);
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_release: got %b expected 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_watchdog();
      int cycles;
      logic early;
      model_en = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      req0_data = 8'h11; req0_key = 8'h22;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < TIMEOUT + 20) begin
         @(negedge clk);
         cycles++;
      end
      checks++;
      if (cycles !== TIMEOUT + 1) begin
         errors++;
         $display("[TB] FAIL wd_latency: got %0d cycles after issue expected %0d", cycles, TIMEOUT + 1);
      end
      checks++;
      if ({out_valid, out_err, out_data, out_tag} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("[TB] FAIL wd_result: got v=%b err=%b data=%h tag=%b expected v=1 err=1 data=00 tag=0",
                  out_valid, out_err, out_data, out_tag);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      @(negedge clk);
      req1_data = 8'h77; req1_key = 8'h07;
      req1_valid = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;
      early = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (out_valid) early = 1'b1;
      end
      man_result = 8'h5C;
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wd_early_out: got %b expected 0", early);
      end
      checks++;
      if ({out_valid, out_err, out_data, out_tag} !== {1'b1, 1'b0, 8'h5C, 1'b1}) begin
         errors++;
         $display("[TB] FAIL wd_done_wins: got v=%b err=%b data=%h tag=%b expected v=1 err=0 data=5c tag=1",
                  out_valid, out_err, out_data, out_tag);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      logic seen;
      model_en = 1'b0;
      @(negedge clk);
      req0_data = 8'hC3; req0_key = 8'h3C;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midwait_busy: got %b expected 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({core_start, out_valid, out_err, out_tag, busy} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_ctrl: got %b expected 00000",
                  {core_start, out_valid, out_err, out_tag, busy});
      end
      checks++;
      if ({core_data, core_key, out_data} !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL async_reset_data: got %h expected 000000", {core_data, core_key, out_data});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < TIMEOUT + 16; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_quiet: got activity=%b expected 0", seen);
      end
   endtask

   task automatic test_boundary();
      logic [7:0] vals [2];
      logic busy_low;
      int cycles;
      vals[0] = 8'hFF;
      vals[1] = 8'h00;
      model_en = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req0_data = vals[k]; req0_key = vals[k]; req0_valid = 1'b1;
         end else begin
            req1_data = vals[k]; req1_key = vals[k]; req1_valid = 1'b1;
         end
         @(negedge clk);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         busy_low = !busy;
         cycles = 0;
         while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (!busy) busy_low = 1'b1;
         end
         checks++;
         if ({out_valid, out_err, out_data, out_tag} !== {1'b1, 1'b0, 8'h00, k[0]}) begin
            errors++;
            $display("[TB] FAIL boundary_%0d_result: got v=%b err=%b data=%h tag=%b expected v=1 err=0 data=00 tag=%b",
                     k, out_valid, out_err, out_data, out_tag, k[0]);
         end
         checks++;
         if (busy_low !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_%0d_busy: got busy dropped=%b expected 0", k, busy_low);
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_%0d_idle: got busy=%b expected 0", k, busy);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = 8'h00; req0_key = 8'h00;
      req1_data = 8'h00; req1_key = 8'h00;
      out_ready = 1'b0;
      man_done = 1'b0;
      man_result = 8'h00;
      model_en = 1'b0;
      test_reset();
      test_single_job();
      test_contention();
      test_backpressure();
      test_watchdog();
      test_reset_mid_wait();
      test_boundary();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
